// File: rtl/memory_stage.sv
// Pipeline memory stage: S1 register, data-memory handshake FSM and writeback register.
// Optional access timeout and sticky mem_err when MEM_TIMEOUT_EN is defined.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_data,
  input  logic [3:0]  rd_in,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mem_result,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_valid,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_alu_q, s1_alu_d;
  logic [31:0] s1_st_q, s1_st_d;
  logic [3:0]  s1_rd_q, s1_rd_d;
  logic        s1_mem_read_q, s1_mem_read_d;
  logic        s1_mem_write_q, s1_mem_write_d;
  logic        s1_reg_write_q, s1_reg_write_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_valid_q, wb_valid_d;
  logic        in_wait;
  logic        abort;
  logic        load;

`ifdef MEM_TIMEOUT_EN
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;

  // Abort on the 15th consecutive WAIT cycle without ack (counter would reach 15).
  assign abort   = in_wait && !dmem_ack && (wait_cnt_q == 4'd14);
  assign mem_err = mem_err_q;
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign in_wait    = (state_q == ST_WAIT);
  assign stall      = in_wait && !dmem_ack && !abort;
  assign load       = !stall;

  assign dmem_req   = in_wait;
  assign dmem_we    = in_wait && s1_mem_write_q;
  assign dmem_addr  = s1_alu_q;
  assign dmem_wdata = s1_st_q;

  assign mem_result   = s1_alu_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_valid     = wb_valid_q;

  always_comb begin
    state_d        = state_q;
    s1_valid_d     = s1_valid_q;
    s1_alu_d       = s1_alu_q;
    s1_st_d        = s1_st_q;
    s1_rd_d        = s1_rd_q;
    s1_mem_read_d  = s1_mem_read_q;
    s1_mem_write_d = s1_mem_write_q;
    s1_reg_write_d = s1_reg_write_q;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    wb_valid_d     = 1'b0;

    if (load) begin
      s1_valid_d     = valid_in && !flush;
      s1_alu_d       = alu_result;
      s1_st_d        = st_data;
      s1_rd_d        = rd_in;
      s1_mem_read_d  = mem_read;
      s1_mem_write_d = mem_write;
      s1_reg_write_d = reg_write;
      state_d        = (s1_valid_d && (mem_read || mem_write)) ? ST_WAIT : ST_IDLE;

      // A flush landing on the ack cycle still kills the completing access's writeback.
      wb_valid_d     = s1_valid_q && !abort && !(in_wait && flush);
      wb_reg_write_d = wb_valid_d && s1_reg_write_q;
      wb_rd_d        = s1_rd_q;
      wb_data_d      = s1_mem_read_q ? dmem_rdata : s1_alu_q;
    end else if (flush) begin
      // Access keeps running so a store still commits; only writeback is lost.
      s1_valid_d = 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q || abort;
    if (load && (state_d == ST_WAIT)) begin
      wait_cnt_d = 4'd0;
    end else if (in_wait && !dmem_ack) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      s1_valid_q     <= 1'b0;
      s1_alu_q       <= 32'd0;
      s1_st_q        <= 32'd0;
      s1_rd_q        <= 4'd0;
      s1_mem_read_q  <= 1'b0;
      s1_mem_write_q <= 1'b0;
      s1_reg_write_q <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_rd_q        <= 4'd0;
      wb_reg_write_q <= 1'b0;
      wb_valid_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= 4'd0;
      mem_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= s1_valid_d;
      s1_alu_q       <= s1_alu_d;
      s1_st_q        <= s1_st_d;
      s1_rd_q        <= s1_rd_d;
      s1_mem_read_q  <= s1_mem_read_d;
      s1_mem_write_q <= s1_mem_write_d;
      s1_reg_write_q <= s1_reg_write_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_valid_q     <= wb_valid_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
`endif
    end
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports alu_result, st_data  in  32 each  ALU result and forwarded store value from the execute stage.
REQ-004 SHALL have ports rd_in  in  4  destination register; valid_in, mem_read, mem_write, reg_write  in  1 each  execute-stage control.
REQ-005 SHALL have port flush  in  1  invalidates the instruction held in the stage register.
REQ-006 SHALL have ports dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  32 each; dmem_rdata  in  32; dmem_ack  in  1  data memory handshake.
REQ-007 SHALL have port mem_result  out  32  stage-register ALU value, forwarded to execute-stage operand muxes.
REQ-008 SHALL have ports wb_data  out  32; wb_rd  out  4; wb_reg_write, wb_valid  out  1 each  writeback register; wb_data is also the forwarding wb_result.
REQ-009 SHALL have ports stall  out  1  freezes upstream stages; mem_err  out  1  sticky access-timeout flag.

Function
REQ-010 SHALL hold one stage register S1 (valid, alu, st, rd, mem_read, mem_write, reg_write), loaded when stall=0, with valid set to valid_in && !flush.
REQ-011 SHALL implement FSM states IDLE and WAIT; IDLE->WAIT on the edge that loads S1 with valid && (mem_read || mem_write); WAIT->IDLE on the edge where dmem_ack=1.
REQ-012 SHALL drive dmem_req=1 only in WAIT, with dmem_we=S1.mem_write, dmem_addr=S1.alu, and dmem_wdata=S1.st, all held stable until ack.
REQ-013 SHALL drive stall=(state==WAIT) && !dmem_ack (combinational), so a zero-wait ack costs no bubble.
REQ-014 SHALL load the writeback register on every edge with stall=0: wb_valid=S1.valid, wb_rd=S1.rd, wb_reg_write=S1.valid && S1.reg_write, and wb_data=dmem_rdata if S1.mem_read else S1.alu.
REQ-015 SHALL set wb_valid=0 and wb_reg_write=0 while stall=1, inserting a bubble rather than repeating the previous write.
REQ-016 SHALL drive mem_result=S1.alu regardless of S1.valid; a load's data is never forwarded from this stage.
REQ-017 SHALL give an ALU-only op a latency of 2 edges from capture to wb_valid, and a memory op 2+k edges, where k is the number of WAIT cycles with dmem_ack=0.
REQ-018 SHALL make flush win over valid_in when both are asserted in the same cycle.
REQ-019 SHALL, when flush arrives in WAIT, let the access complete (the store commits) but suppress writeback (wb_valid=0).
REQ-020 SHALL ignore dmem_ack in IDLE.
REQ-021 SHALL pass addresses unmodified, word access only, with no alignment check.

Reset
REQ-022 SHALL, at a clock edge with rst_n=0, set state=IDLE, S1.valid=0, all S1 fields=0, wb_data=0, wb_rd=0, wb_reg_write=0, wb_valid=0, and mem_err=0.
REQ-023 SHALL, after reset, output dmem_req=0, stall=0, and mem_result=0.
REQ-024 SHALL, on reset during WAIT, abandon the request, with dmem_req low from the cycle after the reset edge; no writeback occurs.

Configuration
REQ-025 SHALL, with macro MEM_TIMEOUT_EN defined, include a 4-bit wait counter that clears on entering WAIT and increments on each WAIT cycle with dmem_ack=0.
REQ-026 SHALL, with MEM_TIMEOUT_EN defined, abort the access when the counter reaches 15 with no ack: state->IDLE, stall=0 in that cycle, writeback suppressed, and mem_err set until reset.
REQ-027 SHALL, without MEM_TIMEOUT_EN, wait indefinitely in WAIT, tie mem_err to 0, and contain no counter logic.

Verification
REQ-028 SHALL cover an ALU op: alu_result=0x0000_0010, rd_in=3, reg_write=1 -> two edges later wb_valid=1, wb_rd=3, wb_data=0x10, and mem_result=0x10 one edge after capture.
REQ-029 SHALL cover a load with 3-cycle ack delay: alu_result=0x100, dmem_rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, stall high 2 cycles, then wb_data=0xDEADBEEF and wb_valid=1.
REQ-030 SHALL cover a store with zero-wait ack: st_data=0x55, alu_result=0x200 -> dmem_we=1, dmem_addr=0x200, dmem_wdata=0x55, stall never high, wb_reg_write=0.
REQ-031 SHALL cover flush and valid_in asserted together: next S1.valid=0, and two edges later wb_valid=0.
REQ-032 SHALL cover rst_n=0 during WAIT: the next cycle shows dmem_req=0, stall=0, wb_valid=0, and state IDLE.
REQ-033 SHALL cover, with MEM_TIMEOUT_EN, a load with ack never asserted: mem_err=1 after 15 WAIT cycles, stall drops, wb_valid stays 0, and mem_err holds until reset.
